// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline constants for the hazard controller: FSM state encodings,
// stall lengths per hazard class, and a small max helper.
package hazard_ctrl_pkg;

    typedef logic [1:0] state_t;

    // FSM states; encoding 2'd3 is never produced and decodes as RUN.
    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_STALL    = 2'd1;
    localparam logic [1:0] ST_MEM_WAIT = 2'd2;

    // Stall lengths (cycles) for each hazard class.
    localparam logic [1:0] LEN_LU            = 2'd1;
    localparam logic [1:0] LEN_BR_ALU        = 2'd1;
    localparam logic [1:0] LEN_BR_LOAD       = 2'd2;
    localparam logic [1:0] LEN_BR_EXMEM_LOAD = 2'd1;

    function automatic logic [1:0] max2(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/hazard_perf_cnt.sv
// Saturating up-counter with enable; holds at all-ones instead of wrapping.
module hazard_perf_cnt #(
    parameter int CNT_W = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    output logic [CNT_W-1:0] o_count
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Increment when enabled unless already saturated.
    always_comb begin
        cnt_d = cnt_q;
        if (i_en && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // Counter register, cleared asynchronously.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_count = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use and branch-operand stalls, data
// memory wait freeze, IF/ID flush on redirect, and stall/flush counters.
// Handshake note: the EX/MEM memory access is "in flight" while
// i_ex_mem_mem_op=1 and completes in the cycle i_dmem_ready=1; until then
// every pipeline register is frozen.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [4:0]       i_id_rs1,
    input  logic [4:0]       i_id_rs2,
    input  logic             i_id_use_rs1,
    input  logic             i_id_use_rs2,
    input  logic             i_id_is_branch,
    input  logic             i_id_redirect,
    input  logic [4:0]       i_id_ex_rd,
    input  logic             i_id_ex_reg_write,
    input  logic             i_id_ex_mem_read,
    input  logic [4:0]       i_ex_mem_rd,
    input  logic             i_ex_mem_reg_write,
    input  logic             i_ex_mem_mem_read,
    input  logic             i_ex_mem_mem_op,
    input  logic             i_dmem_ready,
    output logic             o_stall_front,
    output logic             o_bubble_id_ex,
    output logic             o_flush_if_id,
    output logic             o_freeze,
    output logic [1:0]       o_state,
    output logic [CNT_W-1:0] o_stall_cycles,
    output logic [CNT_W-1:0] o_flush_count
);

    state_t     state_q, state_d;
    logic [1:0] rem_q, rem_d;

    logic       match_ex, match_mem;
    logic       mem_wait;
    logic [1:0] hz_len;
    logic       stall_c, freeze_c;
    logic       eff_stall;

    // Source-vs-destination matches; x0 and unused sources never match.
    always_comb begin
        match_ex  = (i_id_ex_rd != 5'd0) && i_id_ex_reg_write &&
                    ((i_id_use_rs1 && (i_id_rs1 == i_id_ex_rd)) ||
                     (i_id_use_rs2 && (i_id_rs2 == i_id_ex_rd)));
        match_mem = (i_ex_mem_rd != 5'd0) && i_ex_mem_reg_write &&
                    ((i_id_use_rs1 && (i_id_rs1 == i_ex_mem_rd)) ||
                     (i_id_use_rs2 && (i_id_rs2 == i_ex_mem_rd)));
    end

    // Required stall length is the longest of all hazards present.
    always_comb begin
        hz_len = 2'd0;
        if (match_ex && i_id_ex_mem_read) begin
            hz_len = max2(hz_len, LEN_LU);
        end
        if (i_id_is_branch && match_ex && !i_id_ex_mem_read) begin
            hz_len = max2(hz_len, LEN_BR_ALU);
        end
        if (i_id_is_branch && match_ex && i_id_ex_mem_read) begin
            hz_len = max2(hz_len, LEN_BR_LOAD);
        end
        if (i_id_is_branch && match_mem && i_ex_mem_mem_read) begin
            hz_len = max2(hz_len, LEN_BR_EXMEM_LOAD);
        end
    end

    assign mem_wait = i_ex_mem_mem_op && !i_dmem_ready;

    // Next state and raw controls. A memory wait overrides everything and
    // keeps the pending stall count; when it ends, the cycle behaves as the
    // state being resumed (STALL if cycles remain, otherwise RUN).
    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        stall_c   = 1'b0;
        freeze_c  = 1'b0;
        eff_stall = (state_q == ST_STALL) ||
                    ((state_q == ST_MEM_WAIT) && (rem_q != 2'd0));
        if (mem_wait) begin
            freeze_c = 1'b1;
            state_d  = ST_MEM_WAIT;
        end else if (eff_stall) begin
            stall_c = 1'b1;
            rem_d   = (rem_q != 2'd0) ? (rem_q - 2'd1) : 2'd0;
            state_d = (rem_d != 2'd0) ? ST_STALL : ST_RUN;
        end else if (hz_len != 2'd0) begin
            stall_c = 1'b1;
            rem_d   = hz_len - 2'd1;
            state_d = (hz_len > 2'd1) ? ST_STALL : ST_RUN;
        end else begin
            rem_d   = 2'd0;
            state_d = ST_RUN;
        end
    end

    // FSM state and remaining stall count; reset abandons any pending stall.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_RUN;
            rem_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
        end
    end

    // Controls are forced low while reset is held.
    assign o_stall_front  = i_rst_n && stall_c;
    assign o_bubble_id_ex = i_rst_n && stall_c;
    assign o_freeze       = i_rst_n && freeze_c;
    assign o_flush_if_id  = i_rst_n && i_id_redirect && !stall_c && !freeze_c;
    assign o_state        = state_q;

    hazard_perf_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_en    (o_stall_front || o_freeze),
        .o_count (o_stall_cycles)
    );

    hazard_perf_cnt #(.CNT_W(CNT_W)) u_flush_cnt (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_en    (o_flush_if_id),
        .o_count (o_flush_count)
    );

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter: CNT_W, default 32, width of the performance counters.
REQ-002 Ports: i_clk  in  1  single clock, all state rising-edge; i_rst_n  in  1  asynchronous active-low reset.
REQ-003 i_id_rs1, i_id_rs2  in  5 each  source registers of the instruction in ID; i_id_use_rs1, i_id_use_rs2  in  1 each  that source is actually read.
REQ-004 i_id_is_branch  in  1  ID holds a branch/jalr whose comparator uses forwarded operands.
REQ-005 i_id_redirect  in  1  branch resolved taken in ID this cycle.
REQ-006 i_id_ex_rd  in  5; i_id_ex_reg_write  in  1; i_id_ex_mem_read  in  1  (ID/EX is a load).
REQ-007 i_ex_mem_rd  in  5; i_ex_mem_reg_write  in  1; i_ex_mem_mem_read  in  1; i_ex_mem_mem_op  in  1  (EX/MEM is a load or store).
REQ-008 i_dmem_ready  in  1  data memory completes the EX/MEM access this cycle.
REQ-009 o_stall_front  out  1  hold PC and IF/ID; o_bubble_id_ex  out  1  load a bubble into ID/EX.
REQ-010 o_flush_if_id  out  1  load a bubble into IF/ID; o_freeze  out  1  hold every pipeline register.
REQ-011 o_state  out  2  current FSM state; o_stall_cycles, o_flush_count  out  CNT_W  performance counters.

Function
REQ-012 FSM states SHALL be RUN=0, STALL=1, MEM_WAIT=2; encoding 3 SHALL never be entered.
REQ-013 A hazard match SHALL require rd != 0, the matching reg_write set, and the matching i_id_use_rsX set.
REQ-014 Load-use: ID/EX load matching an ID source (any instruction) SHALL cause 1 stall cycle.
REQ-015 Branch on ID/EX ALU result (reg_write, not load) SHALL cause 1 stall cycle.
REQ-016 Branch on ID/EX load SHALL cause 2 stall cycles; branch on EX/MEM load SHALL cause 1 stall cycle.
REQ-017 When several hazards match in RUN, the stall length SHALL be the maximum of their lengths.
REQ-018 In RUN with a hazard: o_stall_front=1, o_bubble_id_ex=1 that same cycle (combinational); if length is 2, next state STALL with remaining count 1, else remain RUN.
REQ-019 In STALL: o_stall_front=1, o_bubble_id_ex=1; hazard inputs ignored; return to RUN next cycle.
REQ-020 Memory wait: whenever i_ex_mem_mem_op=1 and i_dmem_ready=0, o_freeze=1 and all other control outputs 0, in any state; next state MEM_WAIT, remaining STALL count preserved.
REQ-021 In MEM_WAIT with i_dmem_ready=1: o_freeze=0 this cycle; resume to STALL if remaining count nonzero, else RUN, with RUN-state detection applied this cycle.
REQ-022 o_flush_if_id SHALL equal i_id_redirect && !o_stall_front && !o_freeze; a redirect during stall/freeze is ignored.
REQ-023 o_stall_cycles SHALL increment on each cycle with o_stall_front or o_freeze high; o_flush_count on each cycle with o_flush_if_id high; both saturate at all-ones.
REQ-024 Controls SHALL be pure functions of state, remaining count and current inputs; no latency beyond that specified.

Reset
REQ-025 On i_rst_n low, immediately: state RUN, remaining count 0, both counters 0.
REQ-026 During reset, o_freeze, o_stall_front, o_bubble_id_ex, o_flush_if_id SHALL be 0 regardless of inputs.
REQ-027 Reset asserted mid-STALL or mid-MEM_WAIT SHALL abandon the pending stall; first cycle after release is RUN.

Structure
REQ-028 State enum, stall-length constants (LU=1, BR_ALU=1, BR_LOAD=2, BR_EXMEM_LOAD=1) belong in the shared pipeline package.
REQ-029 One sub-module hazard_perf_cnt (saturating CNT_W counter with enable) SHALL be instantiated twice.

Verification
REQ-030 Load x5 in ID/EX, ID add reads x5 -> one cycle stall_front=1, bubble=1, then RUN; stall_cycles=1.
REQ-031 Load x7 in ID/EX, ID beq reads x7 -> two consecutive stall cycles (states RUN then STALL), then RUN; stall_cycles=2.
REQ-032 Load x7 in ID/EX rd=0 or use_rs=0 -> no stall; redirect=1 -> flush_if_id=1, flush_count=1.
REQ-033 Store in EX/MEM, dmem_ready low 3 cycles -> freeze=1 for 3 cycles, state MEM_WAIT, no flush even with redirect=1; then RUN.
REQ-034 Branch-load stall, memory wait in STALL cycle -> freeze for wait, then one remaining stall cycle, total stall_cycles = wait + 2.
REQ-035 Reset pulse in MEM_WAIT -> state RUN, counters 0, all controls 0 asynchronously; counter preload near all-ones -> saturates, no wrap.
